// File: rtl/alk_pkg.sv
// Shared definitions for the ALK loop/flag sequencer: state encoding and the
// default loop counter width.
package alk_pkg;

    localparam int ALK_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alk_state_e;

endpackage : alk_pkg

// File: rtl/alk_wb_strobe.sv
// WBUS readout strobe generator: registers the flag readout requests into the
// mux selects and the active-low group driver enable, one cycle later.
module alk_wb_strobe (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rd_aluf_i,
    input  logic rd_loopf_i,
    output logic wb_aluf_o,
    output logic wb_loopf_o,
    output logic wb_group_ld_o
);

    logic wb_aluf_q,  wb_aluf_d;
    logic wb_loopf_q, wb_loopf_d;
    logic group_ld_q, group_ld_d;

    always_comb begin
        wb_aluf_d  = rd_aluf_i;
        wb_loopf_d = rd_loopf_i;
        // Driver stays on across back-to-back requests of either kind.
        group_ld_d = ~(rd_aluf_i | rd_loopf_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_aluf_q  <= 1'b0;
            wb_loopf_q <= 1'b0;
            group_ld_q <= 1'b1;
        end else begin
            wb_aluf_q  <= wb_aluf_d;
            wb_loopf_q <= wb_loopf_d;
            group_ld_q <= group_ld_d;
        end
    end

    assign wb_aluf_o     = wb_aluf_q;
    assign wb_loopf_o    = wb_loopf_q;
    assign wb_group_ld_o = group_ld_q;

endmodule : alk_wb_strobe

// File: rtl/alk_loop_ctl.sv
// ALK loop sequencer: iteration counter FSM with loop_flag, latched ALU
// carry/sign flags, and the WBUS<31:30> readout strobes.
module alk_loop_ctl
    import alk_pkg::*;
#(
    parameter int CNT_W = ALK_CNT_W
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             ld_count_h,
    input  logic [CNT_W-1:0] wbus_in_h,
    input  logic             step_h,
    input  logic             abort_h,
    input  logic             flag_ld_h,
    input  logic             alu_cout_h,
    input  logic             alu_sign_h,
    input  logic             clr_flags_h,
    input  logic             rd_aluf_h,
    input  logic             rd_loopf_h,
    output logic             alkc_flag_h,
    output logic             aluso_flag_h,
    output logic             loop_flag_h,
    output logic [CNT_W-1:0] count_h,
    output logic             busy_h,
    output logic             alpctl_wb_aluf_h,
    output logic             alpctl_wb_loopf_h,
    output logic             alpctl_wb_group_ld
);

    alk_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             loop_q,  loop_d;
    logic             alkc_q,  alkc_d;
    logic             aluso_q, aluso_d;
    logic             enter_done;
    logic             ld_nonzero;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        enter_done = 1'b0;
        ld_nonzero = 1'b0;

        // Priority: abort, then load (which also reloads a running loop), then step.
        if (abort_h) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (ld_count_h) begin
            count_d = wbus_in_h;
            if (wbus_in_h != '0) begin
                state_d    = ST_RUN;
                ld_nonzero = 1'b1;
            end else begin
                state_d    = ST_DONE;
                enter_done = 1'b1;
            end
        end else if (state_q == ST_RUN && step_h) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
            if (count_q <= CNT_W'(1)) begin
                state_d    = ST_DONE;
                enter_done = 1'b1;
            end
        end else if (state_q == ST_DONE && clr_flags_h) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        loop_d  = loop_q;
        alkc_d  = alkc_q;
        aluso_d = aluso_q;

        // Entry to DONE wins over a simultaneous clear.
        if (enter_done) begin
            loop_d = 1'b1;
        end else if (clr_flags_h || ld_nonzero) begin
            loop_d = 1'b0;
        end

        if (clr_flags_h) begin
            alkc_d  = 1'b0;
            aluso_d = 1'b0;
        end else if (flag_ld_h) begin
            alkc_d  = alu_cout_h;
            aluso_d = alu_sign_h;
        end
    end

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            loop_q  <= 1'b0;
            alkc_q  <= 1'b0;
            aluso_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            loop_q  <= loop_d;
            alkc_q  <= alkc_d;
            aluso_q <= aluso_d;
        end
    end

    alk_wb_strobe u_wb_strobe (
        .clk_i         (clk_h),
        .rst_i         (reset_h),
        .rd_aluf_i     (rd_aluf_h),
        .rd_loopf_i    (rd_loopf_h),
        .wb_aluf_o     (alpctl_wb_aluf_h),
        .wb_loopf_o    (alpctl_wb_loopf_h),
        .wb_group_ld_o (alpctl_wb_group_ld)
    );

    assign alkc_flag_h  = alkc_q;
    assign aluso_flag_h = aluso_q;
    assign loop_flag_h  = loop_q;
    assign count_h      = count_q;
    assign busy_h       = (state_q == ST_RUN);

endmodule : alk_loop_ctl
